// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter (pipeline W stage vs MDU) with MDU-pending scoreboard; optional trace via GRF_WB_TRACE_EN.
// Latency: one cycle from grant to grf_wa/wd/pc; stall/mdu_ready/pipe_hold are combinational.
// Backpressure: the pipeline is held when the MDU wins; the MDU waits at most STARVE_MAX cycles.
module grf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    output logic        pipe_hold,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_wa,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        stall,
    output logic        mdu_inflight,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  cnt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        pipe_req;
    logic        mdu_req;
    logic        force_mdu;
    logic        grant_mdu;
    logic        grant_pipe;

    assign pipe_req   = pipe_we && (pipe_wa != 5'd0);
    assign mdu_req    = mdu_valid;
    assign force_mdu  = mdu_req && (cnt == STARVE_LIM);
    assign grant_mdu  = mdu_req && (!pipe_req || force_mdu);
    assign grant_pipe = pipe_req && !grant_mdu;

    assign mdu_ready    = grant_mdu;
    assign pipe_hold    = pipe_req && grant_mdu;
    assign stall        = busy[rd_a1] | busy[rd_a2];
    assign mdu_inflight = |busy;

    // Clear first, then set, so a relaunch onto the same GPR keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (grant_mdu)
            busy_nxt[mdu_wa] = 1'b0;
        if (sb_set && (sb_set_wa != 5'd0))
            busy_nxt[sb_set_wa] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 4'd0;
            busy   <= 32'd0;
            grf_wa <= 5'd0;
            grf_wd <= 32'd0;
            grf_pc <= 32'd0;
        end else begin
            busy <= busy_nxt;
            if (grant_mdu || !mdu_req)
                cnt <= 4'd0;
            else if (cnt < STARVE_LIM)
                cnt <= cnt + 4'd1;

            if (grant_mdu) begin
                grf_wa <= mdu_wa;
                grf_wd <= mdu_wd;
                grf_pc <= mdu_pc;
            end else if (grant_pipe) begin
                grf_wa <= pipe_wa;
                grf_wd <= pipe_wd;
                grf_pc <= pipe_pc;
            end else begin
                grf_wa <= 5'd0;
            end
        end
    end

`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && grant_mdu && (mdu_wa != 5'd0))
            $display("@%h: $%d <= %h [MDU]", mdu_pc, mdu_wa, mdu_wd);
        else if (!reset && grant_pipe)
            $display("@%h: $%d <= %h", pipe_pc, pipe_wa, pipe_wd);
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: writeback, scoreboard, starvation bound, async reset.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        pipe_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;
    logic        mdu_ready;
    logic        sb_set;
    logic [4:0]  sb_set_wa;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        stall;
    logic        mdu_inflight;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .mdu_ready(mdu_ready),
        .sb_set(sb_set), .sb_set_wa(sb_set_wa), .rd_a1(rd_a1), .rd_a2(rd_a2),
        .stall(stall), .mdu_inflight(mdu_inflight),
        .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pipe_we = 0; pipe_wa = 0; pipe_wd = 0; pipe_pc = 0;
        mdu_valid = 0; mdu_wa = 0; mdu_wd = 0; mdu_pc = 0;
        sb_set = 0; sb_set_wa = 0; rd_a1 = 0; rd_a2 = 0;
        tick();
        check("rst_grf_wa", 32'(grf_wa), 0);
        check("rst_grf_wd", grf_wd, 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_inflight", 32'(mdu_inflight), 0);
        reset = 1'b0;

        // Plain pipeline write
        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
        #1;
        check("p_hold", 32'(pipe_hold), 0);
        check("p_mrdy", 32'(mdu_ready), 0);
        tick();
        check("p_wa", 32'(grf_wa), 5);
        check("p_wd", grf_wd, 32'h1234);
        check("p_pc", grf_pc, 32'h3000);
        pipe_we = 0;
        tick();
        check("idle_wa", 32'(grf_wa), 0);
        check("idle_wd_hold", grf_wd, 32'h1234);

        // Scoreboard set, stall, MDU writeback clears
        sb_set = 1; sb_set_wa = 8;
        tick();
        sb_set = 0; rd_a1 = 8;
        #1;
        check("sb_stall", 32'(stall), 1);
        check("sb_inflight", 32'(mdu_inflight), 1);
        mdu_valid = 1; mdu_wa = 8; mdu_wd = 32'hABCD; mdu_pc = 32'h4000;
        #1;
        check("m_rdy", 32'(mdu_ready), 1);
        check("m_hold", 32'(pipe_hold), 0);
        tick();
        mdu_valid = 0;
        #1;
        check("m_wa", 32'(grf_wa), 8);
        check("m_wd", grf_wd, 32'hABCD);
        check("m_pc", grf_pc, 32'h4000);
        check("m_stall_clr", 32'(stall), 0);
        check("m_inflight_clr", 32'(mdu_inflight), 0);
        rd_a1 = 0;

        // Starvation bound: pipeline wins 4 cycles, MDU forced on 5th
        mdu_valid = 1; mdu_wa = 10; mdu_wd = 32'hBEEF; mdu_pc = 32'h5000;
        pipe_we = 1; pipe_wa = 6; pipe_pc = 32'h6000;
        for (int c = 0; c < 4; c++) begin
            pipe_wd = 32'h100 + c;
            #1;
            check("sv_mrdy", 32'(mdu_ready), 0);
            check("sv_hold", 32'(pipe_hold), 0);
            tick();
            check("sv_wa", 32'(grf_wa), 6);
            check("sv_wd", grf_wd, 32'h100 + c);
        end
        pipe_wd = 32'h104;
        #1;
        check("force_mrdy", 32'(mdu_ready), 1);
        check("force_hold", 32'(pipe_hold), 1);
        tick();
        check("force_wa", 32'(grf_wa), 10);
        check("force_wd", grf_wd, 32'hBEEF);
        mdu_valid = 0;
        #1;
        check("after_hold", 32'(pipe_hold), 0);
        tick();
        check("held_wa", 32'(grf_wa), 6);
        check("held_wd", grf_wd, 32'h104);
        pipe_we = 0;

        // MDU result to $0: accepted, no write, busy untouched
        sb_set = 1; sb_set_wa = 7;
        tick();
        sb_set = 0;
        mdu_valid = 1; mdu_wa = 0; mdu_wd = 32'h55;
        #1;
        check("z_mrdy", 32'(mdu_ready), 1);
        tick();
        mdu_valid = 0; rd_a1 = 7;
        #1;
        check("z_wa", 32'(grf_wa), 0);
        check("z_inflight", 32'(mdu_inflight), 1);
        check("z_stall7", 32'(stall), 1);
        rd_a1 = 0;

        // Same-GPR set and clear in one cycle: set wins
        mdu_valid = 1; mdu_wa = 9; mdu_wd = 32'h99; mdu_pc = 32'h7000;
        sb_set = 1; sb_set_wa = 9;
        tick();
        mdu_valid = 0; sb_set = 0; rd_a2 = 9;
        #1;
        check("sc_wa", 32'(grf_wa), 9);
        check("sc_stall", 32'(stall), 1);
        rd_a2 = 0;

        // Asynchronous reset mid-cycle with busy[3] and cnt=2
        sb_set = 1; sb_set_wa = 3;
        tick();
        sb_set = 0; rd_a1 = 3;
        mdu_valid = 1; mdu_wa = 11; pipe_we = 1; pipe_wa = 6;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("ar_wa", 32'(grf_wa), 0);
        check("ar_stall", 32'(stall), 0);
        check("ar_inflight", 32'(mdu_inflight), 0);
        check("ar_mrdy", 32'(mdu_ready), 0);
        check("ar_hold", 32'(pipe_hold), 0);
        #2;
        reset = 1'b0;
        // cnt restarted from 0: four more pipeline wins before the force
        for (int c = 0; c < 4; c++) begin
            #1;
            check("ar_cnt_wait", 32'(mdu_ready), 0);
            tick();
        end
        check("ar_cnt_force", 32'(mdu_ready), 1);
        mdu_valid = 0; pipe_we = 0; rd_a1 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Sole owner of the GRF write port. Arbitrates between the in-order pipeline writeback (W stage) and the multi-cycle MDU result port, and drives registered WA/WD/PC to the GRF. Holds a 32-entry scoreboard of GPRs with an outstanding MDU write, and raises an issue-stage stall on read-after-write hazards against those GPRs. Bounded starvation: the MDU is never blocked longer than STARVE_MAX cycles.

Parameters:
STARVE_MAX, 4, max consecutive cycles a valid MDU result may lose to the pipeline before a forced grant (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pipe_we  in  1  pipeline W-stage write request
pipe_wa  in  5  pipeline destination GPR
pipe_wd  in  32  pipeline write data
pipe_pc  in  32  PC of pipeline instruction
pipe_hold  out  1  W stage must freeze and re-present the same request next cycle
mdu_valid  in  1  MDU result available
mdu_wa  in  5  MDU destination GPR
mdu_wd  in  32  MDU result data
mdu_pc  in  32  PC of MDU instruction
mdu_ready  out  1  MDU result accepted this cycle
sb_set  in  1  issue stage launches an MDU op this cycle
sb_set_wa  in  5  destination GPR of launched MDU op
rd_a1  in  5  issue-stage source GPR 1
rd_a2  in  5  issue-stage source GPR 2
stall  out  1  source operand pending on MDU write
mdu_inflight  out  1  any scoreboard bit set
grf_wa  out  5  GRF write address (0 = no write)
grf_wd  out  32  GRF write data
grf_pc  out  32  PC for GRF write trace

Behaviour:
- pipe_req = pipe_we && pipe_wa!=0. mdu_req = mdu_valid. A request with wa=0 is a no-op write.
- Starve counter cnt, width 4. States derived from cnt/mdu_req: IDLE (!mdu_req), WAIT (mdu_req, cnt<STARVE_MAX), FORCE (mdu_req, cnt==STARVE_MAX).
- force = mdu_req && cnt==STARVE_MAX. grant_mdu = mdu_req && (!pipe_req || force). grant_pipe = pipe_req && !grant_mdu.
- mdu_ready = grant_mdu; pipe_hold = pipe_req && grant_mdu. Both combinational, same cycle.
- cnt: cleared to 0 on grant_mdu or !mdu_req; else cnt+1 (saturate at STARVE_MAX).
- Write port registered, one-cycle latency. On posedge: grant_mdu -> grf_wa/wd/pc <= mdu_wa/wd/pc. grant_pipe -> pipe values. Neither -> grf_wa <= 0; grf_wd, grf_pc hold.
- MDU result with mdu_wa=0: accepted (mdu_ready=1), grf_wa=0, no scoreboard change.
- Scoreboard busy[31:0], busy[0] hardwired 0. On posedge: sb_set && sb_set_wa!=0 sets busy[sb_set_wa]. grant_mdu clears busy[mdu_wa]. Same GPR set and cleared in one cycle: set wins.
- stall = busy[rd_a1] | busy[rd_a2], combinational from registered busy. Stall drops the cycle after grant; the GRF internal forward of grf_wa supplies the value.
- mdu_inflight = |busy.
- Reset (any time, async): grf_wa=0, grf_wd=0, grf_pc=0, busy=0, cnt=0. Hence stall=0, mdu_inflight=0. Pipeline-request outputs are combinational: pipe_hold/mdu_ready follow inputs, with cnt=0. In-flight MDU results are dropped; the MDU is reset alongside.

Optional Feature:
GRF_WB_TRACE_EN: when defined, each posedge with a committed grf_wa!=0 prints "@%h: $%d <= %h" with PC, WA, WD, plus "[MDU]" suffix for MDU-sourced writes. When undefined, no display statements and no simulation-only logic are compiled.

Test Plan:
- Reset then pipe_we=1, pipe_wa=5, pipe_wd=0x1234, pipe_pc=0x3000 -> next cycle grf_wa=5, grf_wd=0x1234, grf_pc=0x3000; pipe_hold=0.
- sb_set=1, sb_set_wa=8; next cycle rd_a1=8 -> stall=1, mdu_inflight=1. mdu_valid with wa=8, wd=0xABCD, no pipe_req -> mdu_ready=1; next cycle grf_wa=8, wd=0xABCD; stall=0.
- STARVE_MAX=4, pipe_req every cycle, mdu_valid held -> pipe granted cycles 0..3. Cycle 4: mdu_ready=1, pipe_hold=1, MDU value written. Cycle 5: held pipe request written.
- mdu_wa=0, mdu_valid=1 -> mdu_ready=1, grf_wa=0 next cycle, busy unchanged.
- Same cycle: sb_set_wa=9 with grant_mdu on mdu_wa=9 -> busy[9]=1 after edge, stall on rd_a2=9.
- busy[3] set, mdu_valid pending with cnt=2; assert reset mid-cycle asynchronously -> immediately grf_wa=0, stall=0, mdu_inflight=0, cnt=0.
